spatz_mem_responder: RTL and testbench

Memory-side responder for the Spatz VLSU memory ports: accepts `spatz_mem_req_t` requests on `NrMemPorts` independent ready/valid ports, services them from a shared word-addressed storage array, and returns `spatz_mem_resp_t` responses in order per port after a fixed pipeline latency. It sits opposite the VLSU's `spatz_mem_req_o`/`spatz_mem_resp_i` ports in cluster-less testbenches and small standalone integrations. Each port has a credit-based response buffer, so responses are never dropped under response back-pressure.

---
 rtl/spatz_mem_responder_if.sv | 51 +++++
 rtl/spatz_mem_responder.sv | 156 +++++++++++++++
 tb/tb_spatz_mem_responder.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spatz_mem_responder_if.sv
// Request/response bundle between a Spatz VLSU memory port group and its memory responder.
// Carries NrMemPorts independent ready/valid request and response channels.
interface spatz_mem_responder_if #(
    parameter int unsigned NrMemPorts = 1,
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned Elen       = 64
);

    typedef struct packed {
        logic [5:0]           id;
        logic [AddrWidth-1:0] addr;
        logic [1:0]           size;
        logic                 write;
        logic [Elen/8-1:0]    strb;
        logic [Elen-1:0]      data;
        logic                 last;
    } spatz_mem_req_t;

    typedef struct packed {
        logic [5:0]      id;
        logic [Elen-1:0] data;
        logic            err;
        logic            write;
    } spatz_mem_resp_t;

    spatz_mem_req_t  [NrMemPorts-1:0] mem_req;
    logic            [NrMemPorts-1:0] mem_req_valid;
    logic            [NrMemPorts-1:0] mem_req_ready;
    spatz_mem_resp_t [NrMemPorts-1:0] mem_resp;
    logic            [NrMemPorts-1:0] mem_resp_valid;
    logic            [NrMemPorts-1:0] mem_resp_ready;

    modport master (
        output mem_req,
        output mem_req_valid,
        input  mem_req_ready,
        input  mem_resp,
        input  mem_resp_valid,
        output mem_resp_ready
    );

    modport slave (
        input  mem_req,
        input  mem_req_valid,
        output mem_req_ready,
        output mem_resp,
        output mem_resp_valid,
        input  mem_resp_ready
    );

endinterface

// File: rtl/spatz_mem_responder.sv
// Multi-port memory responder for the Spatz VLSU: shared word storage, fixed-latency in-order
// responses per port with credit-based buffering. Define SPATZ_MEM_RSP_STALL_EN for LFSR stalls.
module spatz_mem_responder #(
    parameter int unsigned NrMemPorts = 1,
    parameter int unsigned NumWords   = 1024,
    parameter int unsigned Latency    = 2,
    parameter int unsigned RspDepth   = 4
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    spatz_mem_responder_if.slave bus
);

    localparam int unsigned Elen  = 64;
    localparam int unsigned NrB   = Elen / 8;
    localparam int unsigned OffW  = $clog2(NrB);
    localparam int unsigned IdxW  = $clog2(NumWords);
    localparam int unsigned CntW  = $clog2(RspDepth + 1);
    localparam int unsigned PtrW  = (RspDepth > 1) ? $clog2(RspDepth) : 1;

    logic [Elen-1:0] mem_q [NumWords];

    logic [NrMemPorts-1:0] acc;
    logic [NrMemPorts-1:0] wr;
    logic [NrMemPorts-1:0] push;
    logic [NrMemPorts-1:0] pop;
    logic [IdxW-1:0]       idx       [NrMemPorts];
    logic [Elen-1:0]       rdata     [NrMemPorts];
    logic [Elen-1:0]       push_data [NrMemPorts];

    // Later ports overwrite earlier ones per byte lane.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NrMemPorts; p++) begin
            for (int b = 0; b < NrB; b++) begin
                if (acc[p] && wr[p] && bus.mem_req[p].strb[b]) begin
                    mem_q[idx[p]][b*8 +: 8] <= bus.mem_req[p].data[b*8 +: 8];
                end
            end
        end
    end

    for (genvar p = 0; p < NrMemPorts; p++) begin : g_port
        logic            ready;
        logic            stall;
        logic            rsp_valid;
        logic [CntW-1:0] credit_q, credit_d;
        logic [CntW-1:0] cnt_q, cnt_d;
        logic [PtrW-1:0] wptr_q, wptr_d;
        logic [PtrW-1:0] rptr_q, rptr_d;
        logic [Elen-1:0] fifo_q [RspDepth];
        logic            unused_req;

        assign unused_req = ^{bus.mem_req[p].id, bus.mem_req[p].size, bus.mem_req[p].last,
                              bus.mem_req[p].addr};

        assign idx[p]   = bus.mem_req[p].addr[OffW +: IdxW];
        assign wr[p]    = bus.mem_req[p].write;
        assign rdata[p] = wr[p] ? '0 : mem_q[idx[p]];

`ifdef SPATZ_MEM_RSP_STALL_EN
        logic [15:0] lfsr_q, lfsr_d;

        assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        assign stall  = lfsr_q[0];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                lfsr_q <= 16'hACE1 ^ 16'(p);
            end else begin
                lfsr_q <= lfsr_d;
            end
        end
`else
        assign stall = 1'b0;
`endif

        // Ready looks only at the credit register, never at mem_resp_ready.
        assign ready                 = (credit_q != '0) && !stall;
        assign bus.mem_req_ready[p]  = ready;
        assign acc[p]                = bus.mem_req_valid[p] && ready;
        assign pop[p]                = rsp_valid && bus.mem_resp_ready[p];

        if (Latency == 1) begin : g_lat1
            assign push[p]      = acc[p];
            assign push_data[p] = rdata[p];
        end else begin : g_pipe
            logic [Latency-2:0] vld_q;
            logic [Elen-1:0]    dat_q [Latency-1];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    vld_q <= '0;
                    for (int i = 0; i < Latency - 1; i++) begin
                        dat_q[i] <= '0;
                    end
                end else begin
                    vld_q[0] <= acc[p];
                    dat_q[0] <= rdata[p];
                    for (int i = 1; i < Latency - 1; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        dat_q[i] <= dat_q[i-1];
                    end
                end
            end

            assign push[p]      = vld_q[Latency-2];
            assign push_data[p] = dat_q[Latency-2];
        end

        always_comb begin
            credit_d = credit_q - CntW'(acc[p]) + CntW'(pop[p]);
            cnt_d    = cnt_q + CntW'(push[p]) - CntW'(pop[p]);
            wptr_d   = wptr_q;
            rptr_d   = rptr_q;
            if (push[p]) begin
                wptr_d = (wptr_q == PtrW'(RspDepth - 1)) ? '0 : wptr_q + PtrW'(1);
            end
            if (pop[p]) begin
                rptr_d = (rptr_q == PtrW'(RspDepth - 1)) ? '0 : rptr_q + PtrW'(1);
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                credit_q <= CntW'(RspDepth);
                cnt_q    <= '0;
                wptr_q   <= '0;
                rptr_q   <= '0;
            end else begin
                credit_q <= credit_d;
                cnt_q    <= cnt_d;
                wptr_q   <= wptr_d;
                rptr_q   <= rptr_d;
            end
        end

        always_ff @(posedge clk_i) begin
            if (push[p]) begin
                fifo_q[wptr_q] <= push_data[p];
            end
        end

        assign rsp_valid               = (cnt_q != '0);
        assign bus.mem_resp_valid[p]   = rsp_valid;
        assign bus.mem_resp[p].data    = rsp_valid ? fifo_q[rptr_q] : '0;
        assign bus.mem_resp[p].id      = '0;
        assign bus.mem_resp[p].err     = 1'b0;
        assign bus.mem_resp[p].write   = 1'b0;

        // Credits bound in-flight plus buffered responses to RspDepth.
        a_no_push_when_full : assert property (
            @(posedge clk_i) disable iff (!rst_ni) !(push[p] && (cnt_q == CntW'(RspDepth)))
        );
    end

endmodule

// File: tb/tb_spatz_mem_responder.sv
// Scoreboard bench for spatz_mem_responder: two ports, directed read/write vectors,
// back-pressure, aliasing and mid-operation reset.
module tb_spatz_mem_responder;

    localparam int unsigned NrPorts  = 2;
    localparam int unsigned NumWords = 1024;
    localparam int unsigned Latency  = 2;
    localparam int unsigned RspDepth = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    spatz_mem_responder_if #(.NrMemPorts(NrPorts)) bus ();

    spatz_mem_responder #(
        .NrMemPorts (NrPorts),
        .NumWords   (NumWords),
        .Latency    (Latency),
        .RspDepth   (RspDepth)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [63:0] data;
        int          acc_cyc;
        bit          timed;
    } exp_t;

    exp_t exp0[$];
    exp_t exp1[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic push_exp(input int p, input logic [63:0] data, input bit timed);
        exp_t e;
        e.data    = data;
        e.acc_cyc = cyc;
        e.timed   = timed;
        if (p == 0) exp0.push_back(e);
        else exp1.push_back(e);
    endtask

    // Monitor: a handshake is visible at the negedge before the edge that completes it.
    always @(negedge clk) begin
        exp_t e;
        bit   have;
        if (rst_n) begin
            for (int p = 0; p < NrPorts; p++) begin
                if (bus.mem_resp_valid[p] && bus.mem_resp_ready[p]) begin
                    have = 1'b0;
                    if (p == 0 && exp0.size() > 0) begin
                        e = exp0.pop_front();
                        have = 1'b1;
                    end else if (p == 1 && exp1.size() > 0) begin
                        e = exp1.pop_front();
                        have = 1'b1;
                    end
                    if (!have) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_resp p%0d: got data %h want no response", p,
                                 bus.mem_resp[p].data);
                    end else begin
                        check($sformatf("resp_data p%0d", p), bus.mem_resp[p].data, e.data);
                        check($sformatf("resp_side_fields p%0d", p),
                              64'({bus.mem_resp[p].id, bus.mem_resp[p].err,
                                   bus.mem_resp[p].write}), 64'd0);
                        if (e.timed) begin
                            check($sformatf("resp_latency p%0d", p), 64'(cyc - e.acc_cyc),
                                  64'(Latency));
                        end
                    end
                end
            end
        end
    end

    task automatic issue(input int p, input logic [31:0] addr, input bit wr,
                         input logic [63:0] wdata, input logic [7:0] strb,
                         input logic [63:0] exp_data, input bit track);
        bit ok = 1'b0;
        bus.mem_req[p].addr  = addr;
        bus.mem_req[p].write = wr;
        bus.mem_req[p].data  = wdata;
        bus.mem_req[p].strb  = strb;
        bus.mem_req_valid[p] = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (bus.mem_req_ready[p]) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout p%0d: got ready low want accept", p);
        end else if (track) begin
            push_exp(p, exp_data, bus.mem_resp_ready[p]);
        end
        @(posedge clk);
        #1;
        bus.mem_req_valid[p] = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp0.size() + exp1.size()) != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check(name, 64'(exp0.size() + exp1.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] bp_addr [5];
        logic [63:0] bp_exp  [5];
        int          k;

        bp_addr = '{32'h40, 32'h80, 32'h100, 32'h140, 32'h8};
        bp_exp  = '{64'hDEAD_BEEF_0123_4567, 64'h0000_0000_FFFF_FFFF, 64'h2222_2222_2222_2222,
                    64'hBBBB_BBBB_AAAA_AAAA, 64'h5A5A_5A5A_5A5A_5A5A};

        bus.mem_req        = '0;
        bus.mem_req_valid  = '0;
        bus.mem_resp_ready = '1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        @(negedge clk);
        check("reset_req_ready", 64'(bus.mem_req_ready), 64'h3);
        check("reset_resp_valid", 64'(bus.mem_resp_valid), 64'h0);
        check("reset_resp_data", bus.mem_resp[0].data, 64'h0);
        @(posedge clk);
        #1;

        // Full write then read back with exact latency.
        issue(0, 32'h40, 1'b1, 64'hDEAD_BEEF_0123_4567, 8'hFF, 64'h0, 1'b1);
        issue(0, 32'h40, 1'b0, 64'h0, 8'h00, 64'hDEAD_BEEF_0123_4567, 1'b1);
        drain("drain_basic");

        // Partial write over zero.
        issue(0, 32'h80, 1'b1, 64'h0, 8'hFF, 64'h0, 1'b1);
        issue(0, 32'h80, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'h0, 1'b1);
        issue(0, 32'h80, 1'b0, 64'h0, 8'h00, 64'h0000_0000_FFFF_FFFF, 1'b1);
        drain("drain_strb");

        // Same-cycle read on port 0 and write on port 1 to one word.
        issue(0, 32'h100, 1'b1, 64'h1111_1111_1111_1111, 8'hFF, 64'h0, 1'b1);
        fork
            issue(0, 32'h100, 1'b0, 64'h0, 8'h00, 64'h1111_1111_1111_1111, 1'b1);
            issue(1, 32'h100, 1'b1, 64'h2222_2222_2222_2222, 8'hFF, 64'h0, 1'b1);
        join
        issue(0, 32'h100, 1'b0, 64'h0, 8'h00, 64'h2222_2222_2222_2222, 1'b1);
        drain("drain_rw_same_cycle");

        // Same-cycle writes from both ports: port 1 wins its lanes.
        fork
            issue(0, 32'h140, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 64'h0, 1'b1);
            issue(1, 32'h140, 1'b1, 64'hBBBB_BBBB_BBBB_BBBB, 8'hF0, 64'h0, 1'b1);
        join
        issue(1, 32'h140, 1'b0, 64'h0, 8'h00, 64'hBBBB_BBBB_AAAA_AAAA, 1'b1);
        drain("drain_ww_same_cycle");

        // Address aliasing above NumWords words.
        issue(1, NumWords * 8 + 32'h8, 1'b1, 64'h5A5A_5A5A_5A5A_5A5A, 8'hFF, 64'h0, 1'b1);
        issue(0, 32'h8, 1'b0, 64'h0, 8'h00, 64'h5A5A_5A5A_5A5A_5A5A, 1'b1);
        issue(1, NumWords * 8 + 32'h40, 1'b0, 64'h0, 8'h00, 64'hDEAD_BEEF_0123_4567, 1'b1);
        drain("drain_alias");

        // Back-pressure: only RspDepth accepts while responses are held off.
        bus.mem_resp_ready[0] = 1'b0;
        bus.mem_req[0].write  = 1'b0;
        bus.mem_req[0].strb   = 8'h00;
        k = 0;
        for (int c = 0; c < 10; c++) begin
            bus.mem_req[0].addr  = bp_addr[(k < 5) ? k : 4];
            bus.mem_req_valid[0] = 1'b1;
            @(negedge clk);
            if (bus.mem_req_ready[0]) begin
                push_exp(0, bp_exp[(k < 5) ? k : 4], 1'b0);
                k++;
            end
            @(posedge clk);
            #1;
        end
        check("bp_accept_count", 64'(k), 64'(RspDepth));
        @(negedge clk);
        check("bp_ready_low", 64'(bus.mem_req_ready[0]), 64'h0);
        @(posedge clk);
        #1;
        bus.mem_req_valid[0]  = 1'b0;
        bus.mem_resp_ready[0] = 1'b1;
        @(negedge clk);
        check("bp_ready_in_release_cycle", 64'(bus.mem_req_ready[0]), 64'h0);
        @(negedge clk);
        check("bp_ready_after_handshake", 64'(bus.mem_req_ready[0]), 64'h1);
        @(posedge clk);
        #1;
        drain("drain_backpressure");

        // Reset with responses pending discards them.
        bus.mem_resp_ready[0] = 1'b0;
        repeat (3) issue(0, 32'h40, 1'b0, 64'h0, 8'h00, 64'h0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_reset_resp_valid", 64'(bus.mem_resp_valid[0]), 64'h1);
        rst_n = 1'b0;
        #1;
        check("reset_resp_valid_immediate", 64'(bus.mem_resp_valid), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.mem_resp_ready[0] = 1'b1;
        @(negedge clk);
        check("post_reset_req_ready", 64'(bus.mem_req_ready), 64'h3);
        repeat (10) @(posedge clk);
        #1;
        issue(0, 32'h40, 1'b0, 64'h0, 8'h00, 64'hDEAD_BEEF_0123_4567, 1'b1);
        drain("drain_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
